// File: rtl/sv39_tlb.sv
// Fully associative Sv39 TLB: combinational lookup, tree pseudo-LRU replacement,
// filled by the page-table-walker update port.
module sv39_tlb #(
    parameter int unsigned TLB_ENTRIES = 4,
    parameter int unsigned ASID_WIDTH  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  update_valid_i,
    input  logic [26:0]           update_vpn_i,
    input  logic [ASID_WIDTH-1:0] update_asid_i,
    input  logic                  update_is_2M_i,
    input  logic                  update_is_1G_i,
    input  logic [63:0]           update_content_i,
    input  logic                  lu_access_i,
    input  logic [ASID_WIDTH-1:0] lu_asid_i,
    input  logic [38:0]           lu_vaddr_i,
    output logic                  lu_hit_o,
    output logic [63:0]           lu_content_o,
    output logic                  lu_is_2M_o,
    output logic                  lu_is_1G_o
);

    localparam int unsigned LVL   = $clog2(TLB_ENTRIES);
    localparam int unsigned NODES = TLB_ENTRIES - 1;

    typedef struct packed {
        logic                  valid;
        logic [8:0]            vpn2;
        logic [8:0]            vpn1;
        logic [8:0]            vpn0;
        logic [ASID_WIDTH-1:0] asid;
        logic                  is_2M;
        logic                  is_1G;
        logic [63:0]           content;
    } entry_t;

    entry_t                 tags_q [TLB_ENTRIES];
    entry_t                 new_entry;
    logic [NODES-1:0]       plru_q;
    logic [NODES-1:0]       plru_d;
    logic [TLB_ENTRIES-1:0] match;
    logic                   hit_any;
    int unsigned            hit_e;
    logic [63:0]            hit_content;
    logic                   hit_2M;
    logic                   hit_1G;
    int unsigned            victim_e;
    int unsigned            upd_e;
    logic                   free_found;
    logic                   on_path;
    logic                   unused_vaddr;

    // Heap-ordered tree: node at level l on entry e's path, and the branch taken (1 = right).
    function automatic int unsigned path_node(input int unsigned e, input int unsigned l);
        return (32'd1 << l) - 32'd1 + (e >> (LVL - l));
    endfunction

    function automatic logic path_dir(input int unsigned e, input int unsigned l);
        return ((e >> (LVL - 1 - l)) & 32'd1) != 32'd0;
    endfunction

    assign unused_vaddr = ^lu_vaddr_i[11:0];

    always_comb begin
        match = '0;
        for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
            match[e] = tags_q[e].valid
                     && ((tags_q[e].asid == lu_asid_i) || tags_q[e].content[5])
                     && (tags_q[e].vpn2 == lu_vaddr_i[38:30])
                     && (tags_q[e].is_1G || (tags_q[e].vpn1 == lu_vaddr_i[29:21]))
                     && (tags_q[e].is_1G || tags_q[e].is_2M
                         || (tags_q[e].vpn0 == lu_vaddr_i[20:12]));
        end
    end

    always_comb begin
        hit_any     = 1'b0;
        hit_e       = 0;
        hit_content = '0;
        hit_2M      = 1'b0;
        hit_1G      = 1'b0;
        for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
            if (match[e] && !hit_any) begin
                hit_any     = 1'b1;
                hit_e       = e;
                hit_content = tags_q[e].content;
                hit_2M      = tags_q[e].is_2M;
                hit_1G      = tags_q[e].is_1G;
            end
        end
    end

    assign lu_hit_o     = lu_access_i & hit_any;
    assign lu_content_o = lu_hit_o ? hit_content : '0;
    assign lu_is_2M_o   = lu_hit_o & hit_2M;
    assign lu_is_1G_o   = lu_hit_o & hit_1G;

    // The victim is the one leaf whose whole path agrees with the node bits.
    always_comb begin
        victim_e = 0;
        on_path  = 1'b1;
        for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
            on_path = 1'b1;
            for (int unsigned l = 0; l < LVL; l++) begin
                for (int unsigned n = 0; n < NODES; n++) begin
                    if (n == path_node(e, l) && plru_q[n] != path_dir(e, l)) begin
                        on_path = 1'b0;
                    end
                end
            end
            if (on_path) begin
                victim_e = e;
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        upd_e      = victim_e;
        for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
            if (!tags_q[e].valid && !free_found) begin
                free_found = 1'b1;
                upd_e      = e;
            end
        end
    end

    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.vpn2    = update_vpn_i[26:18];
        new_entry.vpn1    = update_vpn_i[17:9];
        new_entry.vpn0    = update_vpn_i[8:0];
        new_entry.asid    = update_asid_i;
        new_entry.is_1G   = update_is_1G_i;
        new_entry.is_2M   = update_is_2M_i & ~update_is_1G_i;
        new_entry.content = update_content_i;
    end

    // Update path applied after the hit path so it wins on shared nodes.
    always_comb begin
        plru_d = plru_q;
        if (lu_hit_o) begin
            for (int unsigned l = 0; l < LVL; l++) begin
                for (int unsigned n = 0; n < NODES; n++) begin
                    if (n == path_node(hit_e, l)) begin
                        plru_d[n] = ~path_dir(hit_e, l);
                    end
                end
            end
        end
        if (update_valid_i) begin
            for (int unsigned l = 0; l < LVL; l++) begin
                for (int unsigned n = 0; n < NODES; n++) begin
                    if (n == path_node(upd_e, l)) begin
                        plru_d[n] = ~path_dir(upd_e, l);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            plru_q <= '0;
            for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
                tags_q[e] <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
                tags_q[e].valid <= 1'b0;
            end
        end else begin
            plru_q <= plru_d;
            if (update_valid_i) begin
                for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
                    if (e == upd_e) begin
                        tags_q[e] <= new_entry;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sv39_tlb.sv
// Scoreboard bench for sv39_tlb: lookup expectations are queued when driven
// and compared on the falling edge of the same cycle.
module tb_sv39_tlb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        update_valid_i;
    logic [26:0] update_vpn_i;
    logic [0:0]  update_asid_i;
    logic        update_is_2M_i;
    logic        update_is_1G_i;
    logic [63:0] update_content_i;
    logic        lu_access_i;
    logic [0:0]  lu_asid_i;
    logic [38:0] lu_vaddr_i;
    logic        lu_hit_o;
    logic [63:0] lu_content_o;
    logic        lu_is_2M_o;
    logic        lu_is_1G_o;

    typedef struct packed {
        logic        hit;
        logic [63:0] content;
        logic        is_2M;
        logic        is_1G;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    localparam logic [63:0] PTE_A  = 64'h0000_0000_2000_00CF;
    localparam logic [63:0] PTE_B  = 64'h0000_0000_3000_0021;
    localparam logic [63:0] PTE_C  = 64'h0000_0000_4000_00C7;
    localparam logic [63:0] PTE_D  = 64'h0000_0000_5000_00C7;
    localparam logic [63:0] PTE_E  = 64'h0000_0000_6000_00C7;
    localparam logic [63:0] PTE_A2 = 64'h0000_0000_AAAA_00CF;
    localparam logic [63:0] PTE_G  = 64'h0000_0000_7000_00CF;

    sv39_tlb #(.TLB_ENTRIES(4), .ASID_WIDTH(1)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .update_valid_i   (update_valid_i),
        .update_vpn_i     (update_vpn_i),
        .update_asid_i    (update_asid_i),
        .update_is_2M_i   (update_is_2M_i),
        .update_is_1G_i   (update_is_1G_i),
        .update_content_i (update_content_i),
        .lu_access_i      (lu_access_i),
        .lu_asid_i        (lu_asid_i),
        .lu_vaddr_i       (lu_vaddr_i),
        .lu_hit_o         (lu_hit_o),
        .lu_content_o     (lu_content_o),
        .lu_is_2M_o       (lu_is_2M_o),
        .lu_is_1G_o       (lu_is_1G_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".hit"},     64'(lu_hit_o),   64'(e.hit));
            check({t, ".content"}, lu_content_o,    e.content);
            check({t, ".is_2M"},   64'(lu_is_2M_o), 64'(e.is_2M));
            check({t, ".is_1G"},   64'(lu_is_1G_o), 64'(e.is_1G));
        end
    end

    task automatic idle_inputs();
        flush_i          = 1'b0;
        update_valid_i   = 1'b0;
        update_vpn_i     = '0;
        update_asid_i    = '0;
        update_is_2M_i   = 1'b0;
        update_is_1G_i   = 1'b0;
        update_content_i = '0;
        lu_access_i      = 1'b0;
        lu_asid_i        = '0;
        lu_vaddr_i       = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic set_update(input logic [26:0] vpn, input logic asid, input logic is2m,
                              input logic is1g, input logic [63:0] content);
        update_valid_i   = 1'b1;
        update_vpn_i     = vpn;
        update_asid_i    = asid;
        update_is_2M_i   = is2m;
        update_is_1G_i   = is1g;
        update_content_i = content;
    endtask

    task automatic set_lookup(input string tag, input logic acc, input logic [38:0] va,
                              input logic asid, input logic eh, input logic [63:0] ec,
                              input logic e2m, input logic e1g);
        exp_t e;
        lu_access_i = acc;
        lu_vaddr_i  = va;
        lu_asid_i   = asid;
        e.hit       = eh;
        e.content   = ec;
        e.is_2M     = e2m;
        e.is_1G     = e1g;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        set_lookup("in_reset", 1'b1, 39'h00_0000_1000, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        set_lookup("empty", 1'b1, 39'h00_0000_1000, 1'b1, 1'b0, '0, 1'b0, 1'b0);

        // 4K entry A -> entry 0; same-cycle lookup sees the pre-edge contents
        next_cycle();
        set_update(27'h0000001, 1'b1, 1'b0, 1'b0, PTE_A);
        set_lookup("a_same_cycle", 1'b1, 39'h00_0000_1ABC, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        set_lookup("a_hit", 1'b1, 39'h00_0000_1ABC, 1'b1, 1'b1, PTE_A, 1'b0, 1'b0);
        next_cycle();
        set_lookup("a_asid0", 1'b1, 39'h00_0000_1ABC, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // global 1G entry B (2M and 1G both set) -> entry 1
        next_cycle();
        set_update(27'h0040000, 1'b0, 1'b1, 1'b1, PTE_B);
        next_cycle();
        set_lookup("b_1g_global", 1'b1, 39'h00_7FFF_F000, 1'b1, 1'b1, PTE_B, 1'b0, 1'b1);

        // 2M entry C -> entry 2
        next_cycle();
        set_update(27'h0000600, 1'b0, 1'b1, 1'b0, PTE_C);
        next_cycle();
        set_lookup("c_2m", 1'b1, 39'h00_007F_5123, 1'b0, 1'b1, PTE_C, 1'b1, 1'b0);
        next_cycle();
        set_lookup("c_vpn1_miss", 1'b1, 39'h00_0080_0000, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // 4K entry D -> entry 3
        next_cycle();
        set_update(27'h0000123, 1'b0, 1'b0, 1'b0, PTE_D);
        next_cycle();
        set_lookup("d_hit", 1'b1, 39'h00_0012_3000, 1'b0, 1'b1, PTE_D, 1'b0, 1'b0);
        next_cycle();
        set_lookup("no_access", 1'b0, 39'h00_0012_3000, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // touch 0, 2, 1: the pseudo-LRU victim becomes entry 3
        next_cycle();
        set_lookup("touch0", 1'b1, 39'h00_0000_1ABC, 1'b1, 1'b1, PTE_A, 1'b0, 1'b0);
        next_cycle();
        set_lookup("touch2", 1'b1, 39'h00_007F_5123, 1'b0, 1'b1, PTE_C, 1'b1, 1'b0);
        next_cycle();
        set_lookup("touch1", 1'b1, 39'h00_7FFF_F000, 1'b1, 1'b1, PTE_B, 1'b0, 1'b1);
        next_cycle();
        set_update(27'h0000456, 1'b0, 1'b0, 1'b0, PTE_E);
        next_cycle();
        set_lookup("e_hit", 1'b1, 39'h00_0045_6000, 1'b0, 1'b1, PTE_E, 1'b0, 1'b0);
        next_cycle();
        set_lookup("d_evicted", 1'b1, 39'h00_0012_3000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        set_lookup("a_after_evict", 1'b1, 39'h00_0000_1ABC, 1'b1, 1'b1, PTE_A, 1'b0, 1'b0);

        // duplicate of A lands in entry 2 (victim); entry 0 still wins
        next_cycle();
        set_update(27'h0000001, 1'b1, 1'b0, 1'b0, PTE_A2);
        next_cycle();
        set_lookup("dup_lowest", 1'b1, 39'h00_0000_1ABC, 1'b1, 1'b1, PTE_A, 1'b0, 1'b0);
        next_cycle();
        set_lookup("c_evicted", 1'b1, 39'h00_007F_5123, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // flush with a simultaneous update: update dropped, all entries gone
        next_cycle();
        flush_i = 1'b1;
        set_update(27'h0000777, 1'b0, 1'b0, 1'b0, PTE_D);
        set_lookup("flush_pre_edge", 1'b1, 39'h00_0000_1ABC, 1'b1, 1'b1, PTE_A, 1'b0, 1'b0);
        next_cycle();
        set_lookup("flush_upd_drop", 1'b1, 39'h00_0077_7000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        set_lookup("flush_a", 1'b1, 39'h00_0000_1ABC, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        set_lookup("flush_b", 1'b1, 39'h00_7FFF_F000, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        set_lookup("flush_e", 1'b1, 39'h00_0045_6000, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // asynchronous reset mid-cycle
        next_cycle();
        set_update(27'h0000888, 1'b1, 1'b0, 1'b0, PTE_G);
        next_cycle();
        set_lookup("g_hit", 1'b1, 39'h00_0088_8000, 1'b1, 1'b1, PTE_G, 1'b0, 1'b0);
        next_cycle();
        lu_access_i = 1'b1;
        lu_vaddr_i  = 39'h00_0088_8000;
        lu_asid_i   = 1'b1;
        set_update(27'h0000999, 1'b1, 1'b0, 1'b0, PTE_D);
        #1;
        check("pre_rst.hit", 64'(lu_hit_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("async_rst.hit", 64'(lu_hit_o), 64'd0);
        check("async_rst.content", lu_content_o, 64'd0);
        next_cycle();
        rst_i = 1'b0;
        set_lookup("rst_upd_drop", 1'b1, 39'h00_0099_9000, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        set_lookup("rst_g_gone", 1'b1, 39'h00_0088_8000, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        set_update(27'h0000888, 1'b1, 1'b0, 1'b0, PTE_G);
        next_cycle();
        set_lookup("refill_g", 1'b1, 39'h00_0088_8000, 1'b1, 1'b1, PTE_G, 1'b0, 1'b0);

        next_cycle();
        @(negedge clk_i);
        #1;
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sv39_tlb.md
SV39_TLB -- requirements
Module: sv39_tlb

Fully associative Sv39 translation buffer. Filled by the page-table-walker update port; looked up by the MMU.

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 4, number of entries; a power of two, at least 2.
REQ-002 SHALL have parameter ASID_WIDTH, default 1, ASID width.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush_i  in  1  invalidate all entries.
REQ-006 SHALL have port update_valid_i  in  1  write one entry this cycle.
REQ-007 SHALL have port update_vpn_i  in  27  VPN {vpn2,vpn1,vpn0}, 9 bits each.
REQ-008 SHALL have port update_asid_i  in  ASID_WIDTH  ASID of the new entry.
REQ-009 SHALL have port update_is_2M_i / update_is_1G_i  in  1 each  superpage size.
REQ-010 SHALL have port update_content_i  in  64  leaf PTE; bit 5 = G (global).
REQ-011 SHALL have port lu_access_i  in  1  lookup is a real access; qualifies replacement update.
REQ-012 SHALL have port lu_asid_i  in  ASID_WIDTH  lookup ASID.
REQ-013 SHALL have port lu_vaddr_i  in  39  lookup virtual address.
REQ-014 SHALL have port lu_hit_o  out  1  lookup matched.
REQ-015 SHALL have port lu_content_o  out  64  PTE of the matching entry; 0 when no hit.
REQ-016 SHALL have port lu_is_2M_o / lu_is_1G_o  out  1 each  size of the matching entry; 0 when no hit.

Function
REQ-017 Each entry SHALL hold: valid, vpn2/vpn1/vpn0, asid, is_2M, is_1G, content.
REQ-018 Entry e SHALL match when all of the following hold:
- valid;
- asid == lu_asid_i, or content[5] is set;
- vpn2 == lu_vaddr_i[38:30];
- is_1G, or vpn1 == lu_vaddr_i[29:21];
- is_1G, or is_2M, or vpn0 == lu_vaddr_i[20:12].
REQ-019 Lookup SHALL be combinational, zero latency. lu_hit_o = lu_access_i AND any match.
REQ-020 On multiple matches, outputs SHALL come from the lowest-index matching entry.
REQ-021 A lookup in the same cycle as an update or flush SHALL see the pre-edge contents.
REQ-022 Replacement SHALL use a tree pseudo-LRU of TLB_ENTRIES-1 bits:
- each node bit 0 = left subtree is older, 1 = right subtree is older;
- the victim is found by following the node bits from the root.
REQ-023 On each cycle with lu_hit_o=1, the nodes on the hit entry's path SHALL be set to point away from it, effective next edge.
REQ-024 On update_valid_i=1, the lowest-index invalid entry SHALL be written. If none is invalid, the pseudo-LRU victim SHALL be written. The written entry becomes valid at the next edge.
REQ-025 An update SHALL also mark the written entry most-recently-used. If it coincides with a hit, the update's path SHALL take priority at shared nodes.
REQ-026 An update SHALL NOT check for an existing duplicate; REQ-020 resolves any duplicate matches.
REQ-027 When flush_i=1, all valid bits SHALL clear at the next edge. A simultaneous update SHALL be dropped. Pseudo-LRU bits SHALL be left unchanged.
REQ-028 update_is_1G_i and update_is_2M_i both set SHALL be treated as 1G.

Reset
REQ-029 While rst_i=1, independent of clk_i:
- all valid bits 0 and all pseudo-LRU bits 0;
- lu_hit_o=0, lu_content_o=0, lu_is_2M_o=0, lu_is_1G_o=0.
REQ-030 Reset asserted mid-operation SHALL discard any update in that cycle. After release the first update SHALL go to entry 0.

Verification
REQ-031 Reset, then look up 0x0000001000 with lu_access_i=1 -> lu_hit_o=0, lu_content_o=0.
REQ-032 Update 4K entry (vpn 0x0000001, asid 1, content 0x00000000200000CF); next cycle look up 0x0000001ABC, asid 1 -> hit, content 0x200000CF. Same lookup with asid 0 -> miss.
REQ-033 Update 1G entry (vpn2=1, is_1G=1, G=1, asid 0) -> lookup 0x007FFFF000, asid 1 -> hit, lu_is_1G_o=1.
REQ-034 Fill entries 0-3, then hit entries 0, 2, 1 in that order; a fifth update -> written to entry 3. The entry previously in 3 now misses.
REQ-035 flush_i and update_valid_i together, then look up the updated address -> miss. All prior entries miss.
REQ-036 Assert rst_i asynchronously mid-cycle while entries are valid -> lu_hit_o drops to 0 before the next edge.
